// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD command sequencer.
// Includes the HD44780 init sequence and the execution-wait selection rule.
package lcd_pkg;

    localparam int WAIT_W   = 23;
    localparam int INIT_LEN = 6;

    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] ENTRY_INC     = 8'h06;

    // Entry 0 sits in the low byte
    localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ = {
        ENTRY_INC, CLEAR, DISP_ON,
        FUNC_SET_8B2L, FUNC_SET_8B2L, FUNC_SET_8B2L
    };

    typedef enum logic [2:0] {
        PWRUP, INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT
    } state_t;

    // Clear and home (0x01..0x03) need the long execution wait
    function automatic logic [WAIT_W-1:0] sel_wait(
        input logic              rs,
        input logic [7:0]        data,
        input logic [WAIT_W-1:0] w_short,
        input logic [WAIT_W-1:0] w_long
    );
        if (!rs && data[7:2] == 6'd0 && data != 8'd0)
            return w_long;
        return w_short;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational lookup of the power-on init command bytes.
// Out-of-range indices read as 0x00.
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        if (idx < 3'(INIT_LEN))
            data = INIT_SEQ[idx];
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 8-bit init sequencer plus single-write command/data path.
// Each write launches one strobe on the enable-pulse generator.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC   = 720000,
    parameter int WAIT_SHORT  = 1776,
    parameter int WAIT_LONG   = 73440,
    parameter int TIMEOUT_CYC = 8000000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rs,
    input  logic [7:0]        req_data,
    output logic              init_busy,
    output logic              err,
    output logic              LCD_RS,
    output logic              LCD_RW,
    output logic [7:0]        LCD_DATA,
    output logic              strb_start,
    output logic [WAIT_W-1:0] strb_wait,
    input  logic              strb_done
);

    localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'(PWRUP_CYC - 1);
    localparam logic [WAIT_W-1:0] TO_LAST  = WAIT_W'(TIMEOUT_CYC - 1);
    localparam logic [WAIT_W-1:0] W_SHORT  = WAIT_W'(WAIT_SHORT);
    localparam logic [WAIT_W-1:0] W_LONG   = WAIT_W'(WAIT_LONG);
    localparam logic [2:0]        IDX_LAST = 3'(INIT_LEN - 1);

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic [2:0]        idx;
    logic [2:0]        nxt_idx;
    logic [7:0]        rom_data;
    logic              wait_end;

    // The ROM always presents the entry that would be issued next
    assign nxt_idx = (state == PWRUP) ? 3'd0 : idx + 3'd1;

    lcd_init_rom u_rom (
        .idx  (nxt_idx),
        .data (rom_data)
    );

    assign LCD_RW    = 1'b0;
    assign req_ready = (state == IDLE) && !init_busy;
    assign wait_end  = strb_done || (cnt == TO_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= PWRUP;
            cnt        <= '0;
            idx        <= '0;
            init_busy  <= 1'b1;
            err        <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
            strb_start <= 1'b0;
            strb_wait  <= '0;
        end else begin
            strb_start <= 1'b0;
            unique case (state)
                PWRUP: begin
                    if (cnt == PWR_LAST) begin
                        state      <= INIT_ISSUE;
                        idx        <= nxt_idx;
                        LCD_RS     <= 1'b0;
                        LCD_DATA   <= rom_data;
                        strb_start <= 1'b1;
                        strb_wait  <= sel_wait(1'b0, rom_data,
                                               W_SHORT, W_LONG);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT_ISSUE: begin
                    state <= INIT_WAIT;
                    cnt   <= '0;
                end
                INIT_WAIT: begin
                    if (wait_end) begin
                        if (!strb_done)
                            err <= 1'b1;
                        if (idx == IDX_LAST) begin
                            state     <= IDLE;
                            init_busy <= 1'b0;
                        end else begin
                            state      <= INIT_ISSUE;
                            idx        <= nxt_idx;
                            LCD_RS     <= 1'b0;
                            LCD_DATA   <= rom_data;
                            strb_start <= 1'b1;
                            strb_wait  <= sel_wait(1'b0, rom_data,
                                                   W_SHORT, W_LONG);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state      <= ISSUE;
                        LCD_RS     <= req_rs;
                        LCD_DATA   <= req_data;
                        strb_start <= 1'b1;
                        strb_wait  <= sel_wait(req_rs, req_data,
                                               W_SHORT, W_LONG);
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (wait_end) begin
                        if (!strb_done)
                            err <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Command sequencer for the character LCD on the temperature-sensor display path. It runs the HD44780 8-bit power-on init sequence, then accepts single command/character writes from one requester over a valid/ready handshake. For each write it drives LCD_RS/LCD_DATA and launches one enable-strobe transaction on the enable-pulse generator with the correct execution wait. It sits between the display formatter (requester) and the enable-pulse generator (strobe unit).

## Interface
Parameters:
- PWRUP_CYC, 720000: power-on wait before the first init command (15 ms at 48 MHz).
- WAIT_SHORT, 1776: execution wait for ordinary commands and data writes (37 us).
- WAIT_LONG, 73440: execution wait for clear/home, rs=0 with data 0x01..0x03 (1.53 ms).
- TIMEOUT_CYC, 8000000: maximum cycles spent in WAIT before abandoning the command.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset. One clock domain only.
- req_valid  in  1  requester has a write pending.
- req_ready  out  1  sequencer accepts the write this cycle.
- req_rs  in  1  0 = command, 1 = character data.
- req_data  in  8  command or character byte.
- init_busy  out  1  high from reset until the last init command completes.
- err  out  1  sticky strobe-timeout flag.
- LCD_RS  out  1  register select to the panel.
- LCD_RW  out  1  constant 0 (write only).
- LCD_DATA  out  8  data bus to the panel.
- strb_start  out  1  one-cycle launch pulse to the strobe unit.
- strb_wait  out  23  execution wait, valid while strb_start is high.
- strb_done  in  1  one-cycle pulse: strobe plus wait complete.

## Operation
- States: PWRUP, INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT.
- PWRUP: a 23-bit counter runs up to PWRUP_CYC-1, then the FSM enters INIT_ISSUE with init index 0.
- Init ROM, 6 entries, all rs=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- INIT_ISSUE: drives the ROM entry and pulses strb_start, then enters INIT_WAIT. On strb_done the FSM advances the index. After index 5 completes it enters IDLE and clears init_busy.
- IDLE: req_ready=1 only when the FSM is in IDLE and init_busy=0. A cycle with req_valid&req_ready latches rs/data and enters ISSUE.
- ISSUE: LCD_RS and LCD_DATA are updated, strb_start=1, then the FSM enters WAIT.
- WAIT: strb_done returns the FSM to IDLE.
- Wait selection is shared by init and user writes. strb_wait=WAIT_LONG iff rs=0 and data[7:2]==0 and data!=0. Otherwise strb_wait=WAIT_SHORT, including rs=0 with data 0x00.
- Timeout: the wait counter resets on entry to INIT_WAIT or WAIT. If it reaches TIMEOUT_CYC without strb_done, err is set and the command is abandoned:
  - From WAIT: go to IDLE.
  - From INIT_WAIT: advance the index as if done.
- err clears only on reset.
- strb_done is ignored outside INIT_WAIT and WAIT.
- Reset at any point, including mid-wait, aborts immediately and restarts the full PWRUP and init sequence.

## Timing
- Reset values:
  - LCD_RS=0, LCD_DATA=0x00, LCD_RW=0.
  - strb_start=0, strb_wait=0.
  - req_ready=0, init_busy=1, err=0, state PWRUP.
- First strb_start is asserted PWRUP_CYC cycles after reset release.
- Accept in cycle N: LCD_RS/LCD_DATA change and strb_start=1 in cycle N+1. strb_start is low from N+2.
- LCD_RS/LCD_DATA are registered and hold until the next ISSUE or INIT_ISSUE.
- strb_done in cycle M: the FSM is in IDLE and req_ready=1 in cycle M+1.
- Back-to-back writes: minimum spacing between accepts is 3 cycles plus the strobe-unit duration.
- strb_wait is registered together with strb_start.
- req_data is don't-care when req_valid=0. Changes to the request inputs while not ready have no effect.

## Structure
- Package lcd_pkg holds:
  - FSM state enum.
  - Init ROM length and contents.
  - Command constants: FUNC_SET_8B2L=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY_INC=0x06.
  - Wait width constant (23).
- The one natural sub-module is lcd_init_rom: combinational index-to-byte lookup.
- The wait-selection function lives in the package.

## Test plan
Bench uses small parameters (PWRUP_CYC=20, WAIT_SHORT=5, WAIT_LONG=50, TIMEOUT_CYC=200) with a strobe-unit model that pulses strb_done strb_wait cycles after strb_start.
- Release reset -> first strb_start at cycle 20. Six strobes carry 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with waits 5, 5, 5, 5, 50, 5. init_busy falls one cycle after the sixth done.
- rs=1, data 0x41 accepted in cycle N -> LCD_RS=1, LCD_DATA=0x41, strb_start=1, strb_wait=5 in N+1. req_ready=0 until the cycle after done.
- rs=0, data 0x01 and rs=0, data 0x02 -> strb_wait=50 for each. rs=0, data 0x80 and rs=0, data 0x00 -> strb_wait=5.
- req_valid held high with 3 queued writes -> exactly 3 accepts, 3 strb_start pulses, no write lost or duplicated. The panel bus matches each byte in order.
- Strobe model suppresses strb_done on one user write -> err=1 at 200 cycles into WAIT, then IDLE with req_ready=1. err stays 1 through later good writes.
- RST_N asserted mid-WAIT of WAIT_LONG -> all outputs return to reset values immediately. After release the full init sequence reruns.
